gobou_mac_bias: RTL and testbench
=================================

Name: gobou_mac_bias

Overview:
- Fully-connected neuron datapath stage that feeds the gobou ReLU stage.
- Accumulates a run of signed fixed-point pixel×weight products and adds a per-neuron bias.
- Rescales the result back to DWIDTH with saturation, then presents one result per job on pixel_out with a single-cycle out_en strobe.
- pixel_out/out_en connect directly to the ReLU stage's pixel_in/out_en.

Parameters:
- DWIDTH, 16: data/weight/bias/output width, signed two's complement.
- FRACWIDTH, 8: fractional bits of all fixed-point operands; 1.0 = 2^FRACWIDTH.
- LENWIDTH, 12: width of the per-job beat count.
- ACCWIDTH, 44: accumulator width; must be ≥ 2*DWIDTH+LENWIDTH. The accumulator never wraps within a legal job.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- xrst, input, 1: reset, asynchronous, active-high.
- start, input, 1: begin a job; honoured only when busy=0.
- total_in, input, LENWIDTH: number of beats in the job; sampled with start.
- bias, input, signed DWIDTH: neuron bias; sampled with start.
- in_valid, input, 1: pixel/weight beat valid.
- pixel, input, signed DWIDTH: input activation.
- weight, input, signed DWIDTH: weight.
- busy, output, 1: high whenever state ≠ IDLE.
- out_en, output, 1: one-cycle result strobe.
- pixel_out, output, signed DWIDTH: result; held until the next result.
- sat, output, 1: result was clipped; updated together with pixel_out.

Behaviour:
- Reset (xrst=1, any time, including mid-job):
  - state=IDLE; accumulator, product register, count, latched total/bias all cleared.
  - Outputs: busy=0, out_en=0, pixel_out=0, sat=0.
  - No out_en is produced for the aborted job.
- States: IDLE, ACC, DRAIN, BIAS, EMIT.
- IDLE, on start:
  - Latch total_in and bias; clear accumulator and count.
  - If total_in≠0, go to ACC.
  - If total_in=0, go to BIAS (result = bias only).
- ACC:
  - Each cycle with in_valid=1 is one accepted beat: pixel*weight (signed, 2*DWIDTH) is registered into the product register at that edge, and count increments.
  - The registered product is added to the accumulator (sign-extended to ACCWIDTH) one cycle later.
  - Gaps in in_valid are allowed; nothing is added for empty cycles.
  - When the accepted beat brings count to total, go to DRAIN.
- DRAIN:
  - The final product is added. in_valid is ignored. Go to BIAS.
- BIAS:
  - acc ← acc + (sign-extended bias << FRACWIDTH). Go to EMIT.
- EMIT:
  - Arithmetic right shift of acc by FRACWIDTH (floor, no rounding).
  - Saturate to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1]; sat=1 if clipped, else 0.
  - Register pixel_out, sat and out_en=1; go to IDLE.
- Latency:
  - If the last beat is accepted in cycle c, out_en is high in cycle c+4.
  - A zero-length job started in cycle s gives out_en high in cycle s+3.
- out_en:
  - Exactly one cycle per completed job; 0 otherwise.
  - busy is 0 during the out_en cycle, and a start in that cycle is accepted (back-to-back jobs).
- Ignored inputs:
  - start while busy=1 is ignored.
  - in_valid outside ACC is ignored: no count change, no accumulate.
  - Beats beyond total are never accepted.
- total_in, bias, pixel and weight may change freely except where they are sampled.

Test Plan:
1. total=3, pixels 256/512/768, weights 256 each, bias 0, beats back-to-back → pixel_out=1536, sat=0, out_en high exactly 4 cycles after the 3rd beat, one cycle wide.
2. total=1, pixel=-256, weight=512:
   - bias 0 → -512.
   - Rerun with bias 256 → -256.
   - Rerun pixel=-1, weight=1, bias 0 → -1 (floor shift).
3. total=4, pixel=weight=32767 each → pixel_out=32767, sat=1. Same with pixel=-32768, weight=32767 → pixel_out=-32768, sat=1.
4. total=0, bias=768 → pixel_out=768, out_en 3 cycles after start; then an immediate start during the out_en cycle is accepted and completes correctly.
5. total=2 with in_valid gaps (1,0,0,1); start pulsed mid-job; extra in_valid beats during DRAIN/BIAS → only the two beats contribute, the mid-job start has no effect, single out_en.
6. Assert xrst during ACC after 1 of 3 beats → all outputs 0 immediately, no out_en; after release, a fresh job from scenario 1 yields 1536.

Source files
------------

// File: rtl/gobou_mac_bias.sv
`timescale 1ns/1ps
// Fully-connected neuron MAC stage: accumulates signed pixel*weight products, adds the
// neuron bias, rescales to DWIDTH with saturation and strobes one result per job.
module gobou_mac_bias #(
    parameter int unsigned DWIDTH    = 16,
    parameter int unsigned FRACWIDTH = 8,
    parameter int unsigned LENWIDTH  = 12,
    parameter int unsigned ACCWIDTH  = 44
) (
    input  logic                       clk,
    input  logic                       xrst,
    input  logic                       start,
    input  logic [LENWIDTH-1:0]        total_in,
    input  logic signed [DWIDTH-1:0]   bias,
    input  logic                       in_valid,
    input  logic signed [DWIDTH-1:0]   pixel,
    input  logic signed [DWIDTH-1:0]   weight,
    output logic                       busy,
    output logic                       out_en,
    output logic signed [DWIDTH-1:0]   pixel_out,
    output logic                       sat
);

    localparam int unsigned PWIDTH = 2 * DWIDTH;

    // Output range limits, expressed at accumulator width for signed comparison
    localparam logic signed [ACCWIDTH-1:0] L_MAX =
        {{(ACCWIDTH-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [ACCWIDTH-1:0] L_MIN =
        {{(ACCWIDTH-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN,
        S_BIAS,
        S_EMIT
    } state_t;

    state_t                     r_state;
    logic signed [ACCWIDTH-1:0] r_acc;
    logic signed [PWIDTH-1:0]   r_prod;
    logic                       r_prod_vld;
    logic [LENWIDTH-1:0]        r_count;
    logic [LENWIDTH-1:0]        r_total;
    logic signed [DWIDTH-1:0]   r_bias;
    logic                       r_out_en;
    logic                       r_sat;
    logic signed [DWIDTH-1:0]   r_pixel_out;

    logic signed [PWIDTH-1:0]   w_prod;
    logic [LENWIDTH-1:0]        w_count_nxt;
    logic signed [ACCWIDTH-1:0] w_prod_ext;
    logic signed [ACCWIDTH-1:0] w_acc_add;
    logic signed [ACCWIDTH-1:0] w_bias_ext;
    logic signed [ACCWIDTH-1:0] w_shift;
    logic                       w_hi;
    logic                       w_lo;

    // Product of the current beat; the registered copy is folded in one cycle later
    assign w_prod      = PWIDTH'(pixel) * PWIDTH'(weight);
    assign w_count_nxt = r_count + LENWIDTH'(1);
    assign w_prod_ext  = ACCWIDTH'(r_prod);
    assign w_acc_add   = r_prod_vld ? (r_acc + w_prod_ext) : r_acc;
    assign w_bias_ext  = ACCWIDTH'(r_bias) <<< FRACWIDTH;

    // Floor rescale and clip detection for the result
    assign w_shift = r_acc >>> FRACWIDTH;
    assign w_hi    = (w_shift > L_MAX);
    assign w_lo    = (w_shift < L_MIN);

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_prod      <= '0;
            r_prod_vld  <= 1'b0;
            r_count     <= '0;
            r_total     <= '0;
            r_bias      <= '0;
            r_out_en    <= 1'b0;
            r_sat       <= 1'b0;
            r_pixel_out <= '0;
        end else begin
            r_out_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_total    <= total_in;
                        r_bias     <= bias;
                        r_acc      <= '0;
                        r_count    <= '0;
                        r_prod_vld <= 1'b0;
                        r_state    <= (total_in == '0) ? S_BIAS : S_ACC;
                    end
                end
                S_ACC: begin
                    r_acc      <= w_acc_add;
                    r_prod_vld <= in_valid;
                    if (in_valid) begin
                        r_prod  <= w_prod;
                        r_count <= w_count_nxt;
                        if (w_count_nxt == r_total) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    r_acc      <= w_acc_add;
                    r_prod_vld <= 1'b0;
                    r_state    <= S_BIAS;
                end
                S_BIAS: begin
                    r_acc   <= r_acc + w_bias_ext;
                    r_state <= S_EMIT;
                end
                S_EMIT: begin
                    r_out_en <= 1'b1;
                    r_sat    <= w_hi | w_lo;
                    if (w_hi) begin
                        r_pixel_out <= L_MAX[DWIDTH-1:0];
                    end else if (w_lo) begin
                        r_pixel_out <= L_MIN[DWIDTH-1:0];
                    end else begin
                        r_pixel_out <= w_shift[DWIDTH-1:0];
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign out_en    = r_out_en;
    assign pixel_out = r_pixel_out;
    assign sat       = r_sat;

endmodule

// File: tb/tb_gobou_mac_bias.sv
`timescale 1ns/1ps
// Testbench for gobou_mac_bias: directed vector table, hand-written corner sequences
// and randomized jobs checked against an arithmetic reference model.
module tb_gobou_mac_bias;

    localparam int unsigned DW = 16;
    localparam int unsigned FW = 8;
    localparam int unsigned LW = 12;
    localparam int unsigned AW = 44;

    logic                 clk = 1'b0;
    logic                 xrst;
    logic                 start;
    logic [LW-1:0]        total_in;
    logic signed [DW-1:0] bias;
    logic                 in_valid;
    logic signed [DW-1:0] pixel;
    logic signed [DW-1:0] weight;
    logic                 busy;
    logic                 out_en;
    logic signed [DW-1:0] pixel_out;
    logic                 sat;

    int n_cmp = 0;
    int n_bad = 0;

    int bp[$];
    int bw[$];
    int bg[$];
    bit junk;
    bit poke_start;
    bit early;
    bit prev_done;

    typedef struct {
        int total;
        int b;
        int pix;
        int pstep;
        int wt;
        int exp_out;
        bit exp_sat;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    gobou_mac_bias #(
        .DWIDTH   (DW),
        .FRACWIDTH(FW),
        .LENWIDTH (LW),
        .ACCWIDTH (AW)
    ) dut (
        .clk      (clk),
        .xrst     (xrst),
        .start    (start),
        .total_in (total_in),
        .bias     (bias),
        .in_valid (in_valid),
        .pixel    (pixel),
        .weight   (weight),
        .busy     (busy),
        .out_en   (out_en),
        .pixel_out(pixel_out),
        .sat      (sat)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input string what,
                         input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, what, act, exp);
        end
    endtask

    task automatic rand_data();
        pixel  = DW'($urandom);
        weight = DW'($urandom);
    endtask

    // Reference: exact sum of products plus scaled bias, floor-divided by 2^FW, clamped
    function automatic void model(input int total, input int b, output int r, output bit s);
        longint sum;
        sum = 0;
        for (int i = 0; i < total; i++) sum += longint'(bp[i]) * longint'(bw[i]);
        sum += longint'(b) * (longint'(1) << FW);
        sum = sum >>> FW;
        s = 1'b0;
        if (sum > 32767) begin
            sum = 32767;
            s = 1'b1;
        end else if (sum < -32768) begin
            sum = -32768;
            s = 1'b1;
        end
        r = int'(sum);
    endfunction

    // Start a job, feed bp/bw with bg gaps, wait for the strobe and check it
    task automatic run_job(input int total, input int b, input int exp_out,
                           input bit exp_sat, input string nm);
        int n;
        start    = 1'b1;
        total_in = LW'(total);
        bias     = DW'(b);
        in_valid = junk;
        rand_data();
        step();
        start    = 1'b0;
        total_in = LW'($urandom);
        bias     = DW'($urandom);
        if (prev_done) check(nm, "out_en_width", out_en, 0);
        check(nm, "busy_after_start", busy, 1);
        early = 1'b0;
        for (int i = 0; i < total; i++) begin
            for (int g = 0; g < bg[i]; g++) begin
                in_valid = 1'b0;
                start    = poke_start;
                total_in = '0;
                bias     = 16'sh4000;
                rand_data();
                step();
                early |= out_en;
            end
            start    = 1'b0;
            in_valid = 1'b1;
            pixel    = DW'(bp[i]);
            weight   = DW'(bw[i]);
            step();
            if (i < total - 1) early |= out_en;
        end
        n = 1;
        while (!out_en && n < 16) begin
            in_valid = junk;
            rand_data();
            step();
            n++;
        end
        in_valid = 1'b0;
        check(nm, "latency", n, (total == 0) ? 3 : 4);
        check(nm, "early_out_en", early, 0);
        check(nm, "out_en", out_en, 1);
        check(nm, "pixel_out", pixel_out, exp_out);
        check(nm, "sat", sat, exp_sat);
        check(nm, "busy_at_out_en", busy, 0);
        prev_done = 1'b1;
    endtask

    task automatic load_row(input vec_t v);
        bp.delete(); bw.delete(); bg.delete();
        for (int i = 0; i < v.total; i++) begin
            bp.push_back(v.pix + i * v.pstep);
            bw.push_back(v.wt);
            bg.push_back(0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        bit s;
        int total, b, idle, mode;

        tbl[0] = '{total: 3, b: 0,   pix: 256,    pstep: 256, wt: 256,   exp_out: 1536,   exp_sat: 0};
        tbl[1] = '{total: 1, b: 0,   pix: -256,   pstep: 0,   wt: 512,   exp_out: -512,   exp_sat: 0};
        tbl[2] = '{total: 1, b: 256, pix: -256,   pstep: 0,   wt: 512,   exp_out: -256,   exp_sat: 0};
        tbl[3] = '{total: 1, b: 0,   pix: -1,     pstep: 0,   wt: 1,     exp_out: -1,     exp_sat: 0};
        tbl[4] = '{total: 4, b: 0,   pix: 32767,  pstep: 0,   wt: 32767, exp_out: 32767,  exp_sat: 1};
        tbl[5] = '{total: 4, b: 0,   pix: -32768, pstep: 0,   wt: 32767, exp_out: -32768, exp_sat: 1};
        tbl[6] = '{total: 0, b: 768, pix: 0,      pstep: 0,   wt: 0,     exp_out: 768,    exp_sat: 0};
        tbl[7] = '{total: 3, b: 0,   pix: 256,    pstep: 256, wt: 256,   exp_out: 1536,   exp_sat: 0};

        xrst = 1'b1; start = 1'b0; total_in = '0; bias = '0;
        in_valid = 1'b0; pixel = '0; weight = '0;
        junk = 1'b0; poke_start = 1'b0; prev_done = 1'b0;
        step(); step();
        check("reset", "busy", busy, 0);
        check("reset", "out_en", out_en, 0);
        check("reset", "pixel_out", pixel_out, 0);
        check("reset", "sat", sat, 0);
        xrst = 1'b0;
        step();

        // Directed table; every row starts in the previous row's out_en cycle
        for (int k = 0; k < 8; k++) begin
            load_row(tbl[k]);
            run_job(tbl[k].total, tbl[k].b, tbl[k].exp_out, tbl[k].exp_sat, $sformatf("tbl%0d", k));
        end

        // Gapped beats, a start mid-job, and stray in_valid after the last beat
        bp = {256, 512}; bw = {256, 512}; bg = {0, 2};
        junk = 1'b1; poke_start = 1'b1;
        run_job(2, 0, 1280, 1'b0, "gaps");
        junk = 1'b0; poke_start = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            rand_data();
            step();
            early |= out_en;
        end
        in_valid = 1'b0;
        check("gaps", "no_extra_out_en", early, 0);
        check("gaps", "idle_after", busy, 0);
        prev_done = 1'b0;

        // Reset after one of three beats aborts the job
        start = 1'b1; total_in = LW'(3); bias = '0;
        step();
        start = 1'b0; in_valid = 1'b1; pixel = 16'sd256; weight = 16'sd256;
        step();
        in_valid = 1'b0;
        step();
        xrst = 1'b1;
        #1;
        check("abort", "busy", busy, 0);
        check("abort", "out_en", out_en, 0);
        check("abort", "pixel_out", pixel_out, 0);
        check("abort", "sat", sat, 0);
        step(); step();
        xrst = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            early |= out_en;
        end
        check("abort", "no_out_en", early, 0);
        load_row(tbl[0]);
        run_job(3, 0, 1536, 1'b0, "after_abort");

        // Randomized jobs against the reference model
        for (int j = 0; j < 40; j++) begin
            total = $urandom_range(0, 6);
            mode  = $urandom_range(0, 2);
            b     = int'($urandom_range(0, 65535)) - 32768;
            bp.delete(); bw.delete(); bg.delete();
            for (int i = 0; i < total; i++) begin
                if (mode == 0) begin
                    bp.push_back(int'($urandom_range(0, 65535)) - 32768);
                    bw.push_back(int'($urandom_range(0, 65535)) - 32768);
                end else begin
                    bp.push_back(int'($urandom_range(0, 1200)) - 600);
                    bw.push_back(int'($urandom_range(0, 1200)) - 600);
                end
                bg.push_back($urandom_range(0, 2));
            end
            if (mode == 2) b = int'($urandom_range(0, 2000)) - 1000;
            junk = 1'($urandom_range(0, 1));
            idle = $urandom_range(0, 2);
            for (int i = 0; i < idle; i++) begin
                in_valid = junk;
                rand_data();
                step();
                if (prev_done) check("rand_idle", "out_en_width", out_en, 0);
                prev_done = 1'b0;
            end
            model(total, b, r, s);
            run_job(total, b, r, s, $sformatf("rand%0d", j));
        end

        junk = 1'b0;
        step();
        check("final", "out_en_width", out_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
